// File: rtl/sm_ptr_alloc.sv
// Shared-memory pointer allocator: owns the free-slot FIFO, round-robins one writer
// grant per cycle and takes released pointers back from the FREE path.

package sm;
    localparam int unsigned SM_PTR_W = 8;

    typedef logic [SM_PTR_W-1:0] sm_ptr_t;

    typedef enum logic [1:0] {
        WR_OK           = 2'd0,
        WR_ERR_NO_SPACE = 2'd1
    } sm_code_t;

    typedef struct packed {
        sm_code_t code;
        sm_ptr_t  ptr;
    } sm_res_t;
endpackage

module sm_ptr_alloc #(
    parameter int unsigned NUM_WR = 4,
    parameter int unsigned PTR_W  = sm::SM_PTR_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [NUM_WR-1:0] alloc_req_i,
    output logic [NUM_WR-1:0] alloc_ack_o,
    output sm::sm_res_t       alloc_res_o,
    input  logic              free_valid_i,
    input  logic [PTR_W-1:0]  free_ptr_i,
    output logic              free_ready_o,
    output logic              init_done_o,
    output logic [PTR_W:0]    free_cnt_o,
    output logic              free_ovf_o
);

    localparam int unsigned DEPTH = 2 ** PTR_W;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [PTR_W-1:0]    r_fifo [DEPTH];
    logic [PTR_W-1:0]    r_init_cnt;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [IDX_W-1:0]    r_prio;
    logic [NUM_WR-1:0]   r_ack;
    sm::sm_res_t         r_res;
    logic                r_free_ready;
    logic                r_init_done;
    logic                r_ovf;

    logic                w_init_last;
    logic [NUM_WR-1:0]   w_req_m;
    logic                w_gnt_vld;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic [NUM_WR-1:0]   w_grant;
    logic                w_pop;
    logic                w_push;
    logic                w_ovf_set;
    logic [CNT_W-1:0]    w_count_nxt;
    sm::sm_res_t         w_res;

    // Writer index `off` positions after `base`, wrapping at NUM_WR.
    function automatic logic [IDX_W-1:0] f_rr_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
        return IDX_W'((32'(base) + off) % NUM_WR);
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init_last = (r_init_cnt == PTR_W'(DEPTH - 1));
        w_req_m     = alloc_req_i & ~r_ack;
        w_gnt_vld   = 1'b0;
        w_gnt_idx   = '0;
        w_grant     = '0;
        w_pop       = 1'b0;
        w_push      = 1'b0;
        w_ovf_set   = 1'b0;
        w_count_nxt = r_count;
        w_res       = '0;

        case (r_state)
            ST_INIT: begin
                if (w_init_last) begin
                    w_state_nxt = ST_RUN;
                    w_count_nxt = CNT_W'(DEPTH);
                end
            end
            ST_RUN: begin
                // The writer seeing its ack this cycle still holds req; skip it.
                for (int unsigned i = 0; i < NUM_WR; i++) begin
                    if (!w_gnt_vld && w_req_m[f_rr_idx(r_prio, i)]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_idx = f_rr_idx(r_prio, i);
                    end
                end
                if (w_gnt_vld) begin
                    w_grant = NUM_WR'(1) << w_gnt_idx;
                end
                w_pop     = w_gnt_vld && (r_count != '0);
                w_push    = free_valid_i && r_free_ready;
                w_ovf_set = free_valid_i && (r_count == CNT_W'(DEPTH));
                w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
                if (w_gnt_vld) begin
                    // An empty list still acks, but never bypasses a same-cycle release.
                    if (w_pop) begin
                        w_res.code = sm::WR_OK;
                        w_res.ptr  = sm::sm_ptr_t'(r_fifo[r_rd_ptr]);
                    end else begin
                        w_res.code = sm::WR_ERR_NO_SPACE;
                        w_res.ptr  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_init_cnt   <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_prio       <= '0;
            r_ack        <= '0;
            r_res        <= '0;
            r_free_ready <= 1'b0;
            r_init_done  <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + PTR_W'(1);
            end
            if (w_gnt_vld) begin
                r_prio <= f_rr_idx(w_gnt_idx, 1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            r_ack        <= w_grant;
            r_res        <= w_res;
            r_count      <= w_count_nxt;
            r_free_ready <= (w_state_nxt == ST_RUN) && (w_count_nxt < CNT_W'(DEPTH));
            r_init_done  <= (w_state_nxt == ST_RUN);
        end
    end

    // Slot storage: identity fill during INIT, released pointers at the tail afterwards.
    always_ff @(posedge clk_i) begin
        if (r_state == ST_INIT) begin
            r_fifo[r_init_cnt] <= r_init_cnt;
        end else if (w_push) begin
            r_fifo[r_wr_ptr] <= free_ptr_i;
        end
    end

    assign alloc_ack_o  = r_ack;
    assign alloc_res_o  = r_res;
    assign free_ready_o = r_free_ready;
    assign init_done_o  = r_init_done;
    assign free_cnt_o   = r_count;
    assign free_ovf_o   = r_ovf;

endmodule

// File: tb/tb_sm_ptr_alloc.sv
// Bench for sm_ptr_alloc: directed phases plus random traffic, checked against a
// queue-based model of the free list and round-robin grant order.

module tb_sm_ptr_alloc;
    import sm::*;

    localparam int NUM_WR = 4;
    localparam int PTR_W  = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_WR-1:0] alloc_req;
    logic [NUM_WR-1:0] alloc_ack;
    sm_res_t           alloc_res;
    logic              free_valid;
    logic [PTR_W-1:0]  free_ptr;
    logic              free_ready;
    logic              init_done;
    logic [PTR_W:0]    free_cnt;
    logic              free_ovf;
    logic [9:0]        res_bits;

    assign res_bits = alloc_res;

    always #5 clk = ~clk;

    sm_ptr_alloc #(.NUM_WR(NUM_WR), .PTR_W(PTR_W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .alloc_req_i  (alloc_req),
        .alloc_ack_o  (alloc_ack),
        .alloc_res_o  (alloc_res),
        .free_valid_i (free_valid),
        .free_ptr_i   (free_ptr),
        .free_ready_o (free_ready),
        .init_done_o  (init_done),
        .free_cnt_o   (free_cnt),
        .free_ovf_o   (free_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: free list as a queue, outstanding pointers, arbitration bookkeeping.
    int m_q[$];
    int m_out[$];
    bit m_run;
    int m_init_left;
    int m_prio;
    int m_last;
    bit m_ovf;
    int f_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_q.delete();
        m_out.delete();
        m_run       = 1'b0;
        m_init_left = DEPTH;
        m_prio      = 0;
        m_last      = -1;
        m_ovf       = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"},   32'(alloc_ack),  32'd0);
        check({tag, "_res"},   32'(res_bits),   32'd0);
        check({tag, "_ready"}, 32'(free_ready), 32'd0);
        check({tag, "_done"},  32'(init_done),  32'd0);
        check({tag, "_cnt"},   32'(free_cnt),   32'd0);
        check({tag, "_ovf"},   32'(free_ovf),   32'd0);
    endtask

    // Predict the next edge from current inputs, advance one clock, compare all outputs.
    task automatic step();
        logic [NUM_WR-1:0] e_ack;
        logic [9:0]        e_res;
        int                pre;
        int                g;
        e_ack = '0;
        e_res = '0;
        g     = -1;
        if (m_run) begin
            for (int i = 0; i < NUM_WR; i++) begin
                int k;
                k = (m_prio + i) % NUM_WR;
                if (g < 0 && alloc_req[k] && k != m_last) g = k;
            end
            pre = m_q.size();
            if (g >= 0) begin
                e_ack[g] = 1'b1;
                if (pre > 0) begin
                    int p;
                    p = m_q.pop_front();
                    m_out.push_back(p);
                    e_res = {2'd0, 8'(p)};
                end else begin
                    e_res = {2'd1, 8'd0};
                end
                m_prio = (g + 1) % NUM_WR;
            end
            if (free_valid) begin
                if (pre < DEPTH) begin
                    m_q.push_back(int'(free_ptr));
                    if (f_idx >= 0) m_out.delete(f_idx);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end else begin
            m_init_left--;
            if (m_init_left == 0) begin
                m_run = 1'b1;
                for (int i = 0; i < DEPTH; i++) m_q.push_back(i);
            end
        end
        m_last = g;
        @(posedge clk);
        #1;
        check("ack",   32'(alloc_ack),  32'(e_ack));
        check("res",   32'(res_bits),   32'(e_res));
        check("cnt",   32'(free_cnt),   32'(m_q.size()));
        check("ready", 32'(free_ready), 32'(m_run && m_q.size() < DEPTH));
        check("done",  32'(init_done),  32'(m_run));
        check("ovf",   32'(free_ovf),   32'(m_ovf));
    endtask

    initial begin
        int j;
        alloc_req  = '0;
        free_valid = 1'b0;
        free_ptr   = '0;
        f_idx      = -1;
        rst_n      = 1'b0;
        reset_model();

        repeat (2) @(posedge clk);
        #1;
        check_zero("rst0");
        rst_n = 1'b1;

        repeat (DEPTH - 1) step();
        check("init_pending", 32'(init_done), 32'd0);
        step();
        check("init_cnt", 32'(free_cnt), 32'd256);

        for (int n = 0; n < 3; n++) begin
            alloc_req = 4'b0001;
            step();
            check("w0_seq_ptr", 32'(alloc_res.ptr), 32'(n));
            alloc_req = '0;
            step();
        end
        check("cnt_253", 32'(free_cnt), 32'd253);

        alloc_req = '1;
        repeat (12) step();
        alloc_req = '0;
        step();

        repeat (400) begin
            alloc_req = NUM_WR'($urandom);
            if (m_out.size() > 0 && $urandom_range(0, 1) == 1) begin
                j          = int'($urandom_range(0, m_out.size() - 1));
                free_valid = 1'b1;
                free_ptr   = PTR_W'(m_out[j]);
                f_idx      = j;
            end else begin
                free_valid = 1'b0;
                f_idx      = -1;
            end
            step();
        end
        free_valid = 1'b0;
        f_idx      = -1;
        alloc_req  = '0;
        step();

        alloc_req = '1;
        for (int b = 0; b < 600 && m_q.size() > 0; b++) step();
        step();
        check("nospace_code", 32'(alloc_res.code), 32'(WR_ERR_NO_SPACE));
        check("nospace_ptr",  32'(alloc_res.ptr),  32'd0);

        j = -1;
        for (int i = 0; i < m_out.size(); i++) if (m_out[i] == 7) j = i;
        free_valid = 1'b1;
        free_ptr   = 8'd7;
        f_idx      = j;
        step();
        check("bypass_code", 32'(alloc_res.code), 32'(WR_ERR_NO_SPACE));
        check("bypass_cnt",  32'(free_cnt),       32'd1);
        free_valid = 1'b0;
        f_idx      = -1;
        step();
        check("reuse7_code", 32'(alloc_res.code), 32'(WR_OK));
        check("reuse7_ptr",  32'(alloc_res.ptr),  32'd7);
        alloc_req = '0;
        step();

        for (int b = 0; b < 600 && m_out.size() > 0; b++) begin
            free_valid = 1'b1;
            free_ptr   = PTR_W'(m_out[0]);
            f_idx      = 0;
            step();
        end
        free_valid = 1'b0;
        f_idx      = -1;
        step();
        check("full_cnt",   32'(free_cnt),   32'd256);
        check("full_ready", 32'(free_ready), 32'd0);
        free_valid = 1'b1;
        free_ptr   = 8'd5;
        step();
        check("ovf_set", 32'(free_ovf), 32'd1);
        free_valid = 1'b0;
        repeat (3) step();
        check("ovf_sticky", 32'(free_ovf), 32'd1);
        check("ovf_cnt",    32'(free_cnt), 32'd256);

        alloc_req = '1;
        for (int b = 0; b < 600 && m_q.size() > 100; b++) step();
        alloc_req = '0;
        step();
        check("pre_rst_cnt", 32'(free_cnt), 32'd100);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        reset_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (DEPTH) step();
        alloc_req = 4'b0010;
        step();
        check("post_rst_code", 32'(alloc_res.code), 32'(WR_OK));
        check("post_rst_ptr",  32'(alloc_res.ptr),  32'd0);
        alloc_req = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sm_ptr_alloc.md
# sm_ptr_alloc

Pointer allocator and write-port arbiter for the shared memory. Owns the free list of `sm_ptr_t` slots, grants one of `NUM_WR` writers per cycle a free pointer (result as `sm_res_t`), and accepts released pointers from the read/FREE path. It sits between the writer clients and the shared-memory data RAM and is the single authority on slot ownership.

## Interface
- `NUM_WR`, 4: number of writer requesters (≥1).
- `PTR_W`, `sm::SM_PTR_W` (8): pointer width; capacity `DEPTH = 2**PTR_W` slots.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `alloc_req_i`  in  `NUM_WR`  per-writer allocation request; level, held until acked.
- `alloc_ack_o`  out  `NUM_WR`  one-hot, one-cycle pulse; the result on `alloc_res_o` belongs to the acked writer.
- `alloc_res_o`  out  `sm_res_t`  `{code, ptr}`; valid only while `|alloc_ack_o`.
- `free_valid_i`  in  1  release request.
- `free_ptr_i`  in  `PTR_W`  pointer being released.
- `free_ready_o`  out  1  release accepted when `free_valid_i && free_ready_o`.
- `init_done_o`  out  1  free list populated; allocator operational.
- `free_cnt_o`  out  `PTR_W+1`  current number of free slots.
- `free_ovf_o`  out  1  sticky: release attempted while list full (double free).

## Operation
- Free list: circular FIFO, `DEPTH` x `PTR_W` storage, read/write pointers `PTR_W` bits (natural wrap), separate count `PTR_W+1` bits.
- FSM states INIT, RUN.
  - INIT (entered on reset): init counter writes value `i` into entry `i`, `i = 0..DEPTH-1`, one per cycle; no grants, `free_ready_o = 0`; after entry `DEPTH-1` is written -> RUN, count = `DEPTH`.
  - RUN: remains until reset.
- Arbitration (RUN): round-robin over `alloc_req_i` masked by the writer acked in the current cycle (that writer still shows `req` high while seeing its ack). Priority starts at writer 0 after reset; after a grant to writer `k`, highest priority becomes `(k+1) mod NUM_WR`.
- Grant with count > 0: pop head; `code = WR_OK`, `ptr = head`.
- Grant with count = 0: no pop; `code = WR_ERR_NO_SPACE`, `ptr = 0`. Writer is still acked and must re-request if it wants to retry.
- Release (RUN): `free_ready_o = 1` when count < `DEPTH`; accepted pointer pushed at tail. If `free_valid_i` arrives while count = `DEPTH`, it is not accepted and `free_ovf_o` is set until reset. Pointer values are not checked for duplication otherwise.
- Simultaneous grant and release in one cycle: both take effect; count unchanged if grant popped. When count = 0, the grant still returns `WR_ERR_NO_SPACE` (no same-cycle bypass of the released pointer); count becomes 1.
- Allocation order is FIFO: after init, pointers are returned 0,1,2,…; released pointers are reused after all older free entries.

## Timing
- Reset values: `alloc_ack_o = 0`, `alloc_res_o = 0`, `free_ready_o = 0`, `init_done_o = 0`, `free_cnt_o = 0`, `free_ovf_o = 0`; FSM = INIT, RR priority = 0, FIFO pointers = 0.
- INIT lasts exactly `DEPTH` cycles after the first rising edge with `rst_n_i` high; `init_done_o` and `free_ready_o` rise on the next edge, with `free_cnt_o = DEPTH`.
- Allocation latency: request sampled high at edge `t` (arbitration in cycle `t`) -> `alloc_ack_o`/`alloc_res_o` registered, visible in cycle `t+1`. Throughput: one grant per cycle, across different writers.
- A single writer holding `req` continuously is granted every other cycle (masked during its ack cycle).
- `free_cnt_o` is registered and reflects pops/pushes of the previous edge.
- Reset asserted mid-operation clears all state immediately (async); outstanding pointers are forgotten and INIT restarts.

## Test plan
- Reset release, no traffic -> `init_done_o` rises after 256 cycles (PTR_W=8), `free_cnt_o = 256`, all other outputs 0.
- Writer 0 requests three times sequentially -> acks with `WR_OK` and ptrs 0,1,2; `free_cnt_o = 253`.
- All 4 writers request continuously from RUN -> acks in order w0,w1,w2,w3,w0…, ptrs 0,1,2,3,4…, one ack per cycle.
- Allocate 256 slots, then one more request -> ack with `WR_ERR_NO_SPACE`, ptr 0; free ptr 7 in the same cycle as a grant at count 0 -> grant still NO_SPACE, next grant returns ptr 7.
- With 256 free, drive `free_valid_i` ptr 5 -> `free_ready_o = 0`, `free_ovf_o` sets and stays 1, count stays 256.
- Assert `rst_n_i` low mid-traffic (count 100) -> outputs clear asynchronously; after release INIT repeats and first grant returns ptr 0.
